// File: rtl/rob_recovery_ctrl.sv
// Branch-recovery sequencer for the 2-wide ROB: drives the ROB execution state, stalls dispatch and redirects fetch.
// Optional build macro ROB_RECOV_PERF_EN adds recovery/stall performance counters.
module rob_recovery_ctrl #(
  parameter int ROB_SIZE = 32,
  parameter int XLEN     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cdb_mispredict,
  input  logic [XLEN-1:0]           cdb_target,
  input  logic                      retire_mispredict,
  input  logic [XLEN-1:0]           retire_target,
  input  logic [2:0]                rewind_en,
  input  logic                      done_rewinding,
  output logic [1:0]                state,
  output logic                      dispatch_stall,
  output logic                      fetch_redirect,
  output logic [XLEN-1:0]           redirect_pc,
  output logic [$clog2(ROB_SIZE):0] rewind_count,
  output logic                      busy
`ifdef ROB_RECOV_PERF_EN
  ,
  output logic [31:0]               perf_recoveries,
  output logic [31:0]               perf_stall_cycles
`endif
);

  localparam int CW = $clog2(ROB_SIZE) + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(ROB_SIZE);

  typedef enum logic [1:0] {IDLE, PARTIAL, FLUSH, REDIRECT} fsm_t;

  fsm_t            fsm_reg, fsm_next;
  logic [XLEN-1:0] target_reg, target_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [1:0]      rewind_pop;
  logic [CW:0]     count_sum;
  logic [CW-1:0]   count_sat;

  // Illegal rewind_en codes still count per set bit.
  assign rewind_pop = {1'b0, rewind_en[0]} + {1'b0, rewind_en[1]} + {1'b0, rewind_en[2]};
  assign count_sum  = {1'b0, count_reg} + {{(CW-1){1'b0}}, rewind_pop};
  assign count_sat  = (count_sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : count_sum[CW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_reg    <= IDLE;
      target_reg <= '0;
      count_reg  <= '0;
    end else begin
      fsm_reg    <= fsm_next;
      target_reg <= target_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    fsm_next    = fsm_reg;
    target_next = target_reg;
    count_next  = count_reg;
    case (fsm_reg)
      IDLE: begin
        // A retiring mispredict is the oldest one, so it beats the CDB.
        if (retire_mispredict) begin
          fsm_next    = FLUSH;
          target_next = retire_target;
          count_next  = '0;
        end else if (cdb_mispredict) begin
          fsm_next    = PARTIAL;
          target_next = cdb_target;
          count_next  = '0;
        end
      end
      PARTIAL: begin
        count_next = count_sat;
        if (retire_mispredict) begin
          fsm_next    = FLUSH;
          target_next = retire_target;
        end else if (rewind_en == 3'b000 || done_rewinding) begin
          fsm_next = REDIRECT;
        end
      end
      FLUSH: begin
        count_next = count_sat;
        if (done_rewinding) fsm_next = REDIRECT;
      end
      REDIRECT: fsm_next = IDLE;
      default:  fsm_next = IDLE;
    endcase
  end

  always_comb begin
    case (fsm_reg)
      PARTIAL: state = 2'd1;
      FLUSH:   state = 2'd2;
      default: state = 2'd0;
    endcase
    dispatch_stall = (fsm_reg != IDLE);
    busy           = (fsm_reg != IDLE);
    fetch_redirect = (fsm_reg == REDIRECT);
    redirect_pc    = target_reg;
    rewind_count   = count_reg;
  end

`ifdef ROB_RECOV_PERF_EN
  logic [31:0] recov_reg, stall_reg;

  // Only IDLE exits count, so a PARTIAL->FLUSH escalation is one recovery.
  always_ff @(posedge clock) begin
    if (reset) begin
      recov_reg <= '0;
      stall_reg <= '0;
    end else begin
      if (fsm_reg == IDLE && fsm_next != IDLE) recov_reg <= recov_reg + 32'd1;
      if (fsm_reg != IDLE) stall_reg <= stall_reg + 32'd1;
    end
  end

  assign perf_recoveries   = recov_reg;
  assign perf_stall_cycles = stall_reg;
`endif

`ifdef SIM
  always_ff @(posedge clock)
    if (!reset) assert (rewind_en inside {3'b000, 3'b001, 3'b011, 3'b111});
`endif

endmodule
